// File: rtl/jserial_addsub.sv
// Bit-serial adder/subtractor: operands arrive LSB first, one bit per clock,
// and the completed WIDTH-bit result is published with a one-cycle isvalid pulse.
module jserial_addsub #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             carryin,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic [WIDTH-1:0] y,
    output logic             carryout,
    output logic             overflow,
    output logic             isvalid,
    output logic             currentsum,
    output logic             currentcarryout,
    output logic [CW-1:0]    currentbitcount
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             csum_q, csum_d;
    logic             ccout_q, ccout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             absorb;
    logic             last;
    logic             sub_eff;
    logic             cin;
    logic             bb;
    logic             s;
    logic             cn;
    logic [WIDTH-1:0] full;

    // On the accept edge the live inputs are used; afterwards the latched mode and running carry.
    assign absorb  = (state_q == RUN) || start;
    assign sub_eff = (state_q == IDLE) ? sub : sub_q;
    assign cin     = (state_q == IDLE) ? (carryin ^ sub) : carry_q;
    assign last    = (state_q == IDLE) ? (WIDTH == 1) : (cnt_q == CW'(WIDTH - 1));

    assign bb = b ^ sub_eff;
    assign s  = a ^ bb ^ cin;
    assign cn = (a & bb) | (a & cin) | (bb & cin);

    // Earlier sum bits sit below the incoming one, so after WIDTH bits the first lands at y[0].
    generate
        if (WIDTH > 1) begin : g_acc
            logic [WIDTH-2:0] acc_q;
            logic [WIDTH-2:0] acc_d;

            assign full  = {s, acc_q};
            assign acc_d = full[WIDTH-1:1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc_q <= '0;
                end else if (absorb) begin
                    acc_q <= acc_d;
                end
            end
        end else begin : g_noacc
            assign full = s;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        csum_d  = csum_q;
        ccout_d = ccout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sub_d = sub;
                    cnt_d = CW'(1);
                    if (!last) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (absorb) begin
            carry_d = cn;
            csum_d  = s;
            ccout_d = cn;
            if (last) begin
                y_d     = full;
                cout_d  = cn;
                // A single-bit result has no separate sign bit, so no signed overflow is reported.
                ovf_d   = (WIDTH > 1) ? (cin ^ cn) : 1'b0;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            csum_q  <= 1'b0;
            ccout_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            csum_q  <= csum_d;
            ccout_q <= ccout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy            = (state_q == RUN);
    assign y               = y_q;
    assign carryout        = cout_q;
    assign overflow        = ovf_q;
    assign isvalid         = valid_q;
    assign currentsum      = csum_q;
    assign currentcarryout = ccout_q;
    assign currentbitcount = cnt_q;

endmodule

// File: tb/tb_jserial_addsub.sv
// Scoreboard bench for jserial_addsub at WIDTH 4, 8 and 1: the driver queues
// expected results, per-instance monitors check them whenever isvalid pulses.
module tb_jserial_addsub;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       o;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    exp_t q4[$];
    exp_t q8[$];
    exp_t q1[$];
    exp_t e4, e8, e1;

    logic       st4 = 0, sb4 = 0, ci4 = 0, a4 = 0, b4 = 0;
    logic       busy4, co4, ov4, iv4, cs4, cc4;
    logic [3:0] y4;
    logic [2:0] cnt4;

    logic       st8 = 0, sb8 = 0, ci8 = 0, a8 = 0, b8 = 0;
    logic       busy8, co8, ov8, iv8, cs8, cc8;
    logic [7:0] y8;
    logic [3:0] cnt8;

    logic       st1 = 0, sb1 = 0, ci1 = 0, a1 = 0, b1 = 0;
    logic       busy1, co1, ov1, iv1, cs1, cc1;
    logic [0:0] y1;
    logic [0:0] cnt1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jserial_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .sub(sb4), .carryin(ci4), .a(a4), .b(b4),
        .busy(busy4), .y(y4), .carryout(co4), .overflow(ov4), .isvalid(iv4),
        .currentsum(cs4), .currentcarryout(cc4), .currentbitcount(cnt4)
    );

    jserial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .sub(sb8), .carryin(ci8), .a(a8), .b(b8),
        .busy(busy8), .y(y8), .carryout(co8), .overflow(ov8), .isvalid(iv8),
        .currentsum(cs8), .currentcarryout(cc8), .currentbitcount(cnt8)
    );

    jserial_addsub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .sub(sb1), .carryin(ci1), .a(a1), .b(b1),
        .busy(busy1), .y(y1), .carryout(co1), .overflow(ov1), .isvalid(iv1),
        .currentsum(cs1), .currentcarryout(cc1), .currentbitcount(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic drive(input int d, input logic st, input logic sbv, input logic civ,
                         input logic av, input logic bv);
        case (d)
            0: begin st4 = st; sb4 = sbv; ci4 = civ; a4 = av; b4 = bv; end
            1: begin st8 = st; sb8 = sbv; ci8 = civ; a8 = av; b8 = bv; end
            default: begin st1 = st; sb1 = sbv; ci1 = civ; a1 = av; b1 = bv; end
        endcase
    endtask

    function automatic logic busy_of(input int d);
        case (d)
            0: return busy4;
            1: return busy8;
            default: return busy1;
        endcase
    endfunction

    // Called just after a rising edge; the accept happens on the next one.
    // poke=1 holds start high with flipped sub/carryin during RUN, which must be ignored.
    task automatic issue(input int d, input logic [7:0] av, input logic [7:0] bv,
                         input logic sbv, input logic civ, input logic [7:0] ey,
                         input logic ec, input logic eo, input logic poke);
        int   w;
        exp_t e;
        w = (d == 0) ? 4 : (d == 1) ? 8 : 1;
        e.y = ey;
        e.c = ec;
        e.o = eo;
        e.cyc = cyc + w;
        case (d)
            0: q4.push_back(e);
            1: q8.push_back(e);
            default: q1.push_back(e);
        endcase
        for (int i = 0; i < w; i++) begin
            if (i == 0) drive(d, 1'b1, sbv, civ, av[i], bv[i]);
            else        drive(d, poke, poke ? ~sbv : sbv, poke ? ~civ : civ, av[i], bv[i]);
            @(posedge clk);
            #1;
            if (i < w - 1) chk($sformatf("busy_d%0d_bit%0d", d, i), busy_of(d), 1);
        end
        drive(d, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (iv4) begin
            if (q4.size() == 0) begin
                total++; bad++;
                $display("FAIL w4_unexpected_valid: got pulse expected none");
            end else begin
                e4 = q4.pop_front();
                chk("w4_y", y4, e4.y);
                chk("w4_cout", co4, e4.c);
                chk("w4_ovf", ov4, e4.o);
                chk("w4_latency", cyc, e4.cyc);
                chk("w4_busy_done", busy4, 0);
                chk("w4_count", cnt4, 4);
                chk("w4_cursum", cs4, e4.y[3]);
                chk("w4_curcout", cc4, e4.c);
            end
        end
    end

    always @(negedge clk) begin
        if (iv8) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL w8_unexpected_valid: got pulse expected none");
            end else begin
                e8 = q8.pop_front();
                chk("w8_y", y8, e8.y);
                chk("w8_cout", co8, e8.c);
                chk("w8_ovf", ov8, e8.o);
                chk("w8_latency", cyc, e8.cyc);
                chk("w8_count", cnt8, 8);
                chk("w8_cursum", cs8, e8.y[7]);
            end
        end
    end

    always @(negedge clk) begin
        if (iv1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL w1_unexpected_valid: got pulse expected none");
            end else begin
                e1 = q1.pop_front();
                chk("w1_y", y1, e1.y);
                chk("w1_cout", co1, e1.c);
                chk("w1_ovf", ov1, e1.o);
                chk("w1_latency", cyc, e1.cyc);
                chk("w1_busy", busy1, 0);
                chk("w1_count", cnt1, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("rst_busy", busy4, 0);
        chk("rst_y", y4, 0);
        chk("rst_valid", iv4, 0);
        chk("rst_count", cnt4, 0);
        chk("rst_y8", y8, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // WIDTH=4 add, including back-to-back starts during isvalid
        issue(0, 8'd5, 8'd5, 1'b0, 1'b0, 8'd10, 1'b0, 1'b1, 1'b0);
        idle(3);
        issue(0, 8'd6, 8'd10, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        issue(0, 8'd10, 8'd5, 1'b0, 1'b0, 8'd15, 1'b0, 1'b0, 1'b0);
        issue(0, 8'd7, 8'd8, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        idle(2);
        // WIDTH=4 subtract, with borrow-in and with start poked during RUN
        issue(0, 8'd5, 8'd3, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0);
        issue(0, 8'd3, 8'd5, 1'b1, 1'b0, 8'd14, 1'b0, 1'b0, 1'b0);
        issue(0, 8'd5, 8'd3, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
        issue(0, 8'd8, 8'd1, 1'b1, 1'b0, 8'd7, 1'b1, 1'b1, 1'b1);
        idle(2);
        chk("hold_y", y4, 7);
        chk("hold_count", cnt4, 4);

        issue(1, 8'd200, 8'd100, 1'b0, 1'b1, 8'd45, 1'b1, 1'b0, 1'b0);
        issue(1, 8'd127, 8'd1, 1'b0, 1'b0, 8'd128, 1'b0, 1'b1, 1'b0);
        issue(1, 8'd0, 8'd1, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0);
        idle(2);

        issue(2, 8'd1, 8'd1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        issue(2, 8'd0, 8'd0, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        issue(2, 8'd0, 8'd1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Abort a WIDTH=4 operation after two bits; no result must appear
        drive(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_abort_busy", busy4, 1);
        chk("pre_abort_count", cnt4, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", busy4, 0);
        chk("abort_y", y4, 0);
        chk("abort_cout", co4, 0);
        chk("abort_ovf", ov4, 0);
        chk("abort_valid", iv4, 0);
        chk("abort_count", cnt4, 0);
        chk("abort_cursum", cs4, 0);
        chk("abort_curcout", cc4, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(0, 8'd1, 8'd2, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
        idle(12);

        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
